led_pattern_sequencer: RTL and testbench
========================================

// Module: led_pattern_sequencer
// PURPOSE
//  Top-level controller for the DE10 LED pattern generators (counter, shifter, ping-pong, ...).
//  Selects one of NUM_PAT generators and routes its 10-bit output to LEDR[9:0].
//  Advances on a debounced KEY press or on an auto-dwell timer.
//  Gives each newly selected generator a clean 1-cycle reset and a short LED blank.
//  Drives each generator's rst/en; generators run free of any other control.
// PARAMETERS
//  NUM_PAT       4         number of pattern generators, 2..8
//  DEB_CYCLES    1000000   debounce hold time in clk cycles (20 ms @ 50 MHz), >=1
//  DWELL_CYCLES  250000000 auto-advance period in clk cycles (5 s @ 50 MHz), >=1
//  BLANK_CYCLES  5000000   LED blank time after a switch (100 ms), 0 allowed
// PORTS
//  clk       in   1           50 MHz clock
//  rst       in   1           synchronous, active-high reset
//  btn_n     in   1           raw KEY, active-low, asynchronous, bouncy
//  sw_auto   in   1           1 = auto-advance every DWELL_CYCLES
//  sw_pause  in   1           1 = freeze the selected generator (en low) and the dwell timer
//  pat_in    in   NUM_PAT*10  generator outputs; pattern i = pat_in[i*10 +: 10]
//  pat_rst   out  NUM_PAT     per-generator sync reset
//  pat_en    out  NUM_PAT     per-generator enable
//  led       out  10          LED drive (registered)
//  sel       out  3           index of the current pattern
//  busy      out  1           high while switching (state != RUN)
// BEHAVIOUR
//  Reset (rst=1), registered outputs:
//   - sel=0, led=0, state=SW_RST, dwell=0, debounce stable level = released.
//   - pat_rst = all ones and pat_en = 0 while rst is high (combinational).
//  Button path:
//   - 2-FF synchronizer, then invert.
//   - Counter clears whenever the synced level equals the stable level.
//   - stable takes the synced level after DEB_CYCLES consecutive differing cycles.
//   - btn_pulse = 1-cycle pulse on stable 0->1 (press); release makes no pulse.
//   - Press-to-pulse latency is DEB_CYCLES+2 .. DEB_CYCLES+4 clocks.
//  Dwell timer:
//   - Counts only in RUN with sw_auto=1 and sw_pause=0; holds when paused.
//   - Clears when sw_auto=0 or on any advance.
//   - dwell_tick is asserted when count == DWELL_CYCLES-1.
//  FSM states RUN, SW_RST, BLANK:
//   - RUN: adv = btn_pulse | dwell_tick. When adv=1:
//     - sel <= (sel==NUM_PAT-1) ? 0 : sel+1, then go to SW_RST.
//     - btn_pulse and dwell_tick in the same cycle give exactly one advance.
//   - SW_RST: exactly 1 cycle, then go to BLANK (or to RUN if BLANK_CYCLES==0).
//   - BLANK: exactly BLANK_CYCLES cycles, then go to RUN.
//   - btn_pulse or dwell_tick outside RUN are dropped, not queued.
//  Outputs:
//   - pat_rst[i] = rst | (state==SW_RST & sel==i).
//   - pat_en[i] = ~rst & state==RUN & sel==i & ~sw_pause. Unselected generators stay disabled and hold.
//   - led <= (state==RUN) ? pat_in[sel*10 +: 10] : 0. This gives 1-cycle latency from pat_in.
//   - busy = (state != RUN).
//  rst mid-operation: any state returns to the reset values above; the sequence restarts at pattern 0.
// TESTING (NUM_PAT=4, DEB_CYCLES=4, DWELL_CYCLES=16, BLANK_CYCLES=3)
//  1. Reset release:
//     - pat_rst=4'b1111 during rst.
//     - pat_rst=4'b0001 for 1 cycle, then led=0 and busy=1 for 3 cycles.
//     - Then RUN with pat_en=4'b0001, and led equals pat_in[9:0] one cycle later.
//  2. Bounce: btn_n low pulses of 1..3 cycles -> no change, sel stays 0.
//     A 10-cycle press -> sel=1, a single pat_rst=4'b0010 pulse, and no advance on release.
//  3. Auto mode with sel=3: after 16 RUN cycles -> sel=0 (wrap) and pat_rst=4'b0001.
//     RUN cycles between successive advances = 16.
//  4. Pause after 8 dwell counts: pat_en=0, led holds pat_in of sel, no advance for 100 cycles.
//     Unpause -> advance after 8 more RUN cycles.
//  5. Simultaneous btn_pulse and dwell_tick -> sel+1 only.
//     Button press timed to pulse during BLANK -> dropped; sel unchanged at next RUN.
//  6. rst asserted mid-BLANK with sel=2 -> next cycle sel=0, led=0, pat_rst=4'b1111.
//     After release, sequence 1 repeats.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: picks one of NUM_PAT LED pattern generators and routes it to the LEDs.
// Latency: led is registered, 1 cycle from pat_in; button press reaches an advance DEB_CYCLES+3 cycles after btn_n falls.
// Backpressure: none; advance requests arriving while a switch is in progress are dropped.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   btn_n     - raw active-low push button (asynchronous, bouncy)
//   sw_auto   - 1 = advance automatically every DWELL_CYCLES RUN cycles
//   sw_pause  - 1 = freeze the selected generator and the dwell timer
//   pat_in    - generator outputs, pattern i = pat_in[i*10 +: 10]
//   pat_rst   - per-generator sync reset (1-cycle pulse on selection)
//   pat_en    - per-generator enable (only the selected one, only in RUN)
//   led       - registered LED drive, blanked while switching
//   sel       - index of the current pattern
//   busy      - high while a switch is in progress
module led_pattern_sequencer #(
  parameter int NUM_PAT      = 4,
  parameter int DEB_CYCLES   = 1000000,
  parameter int DWELL_CYCLES = 250000000,
  parameter int BLANK_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_n,
  input  logic                  sw_auto,
  input  logic                  sw_pause,
  input  logic [NUM_PAT*10-1:0] pat_in,
  output logic [NUM_PAT-1:0]    pat_rst,
  output logic [NUM_PAT-1:0]    pat_en,
  output logic [9:0]            led,
  output logic [2:0]            sel,
  output logic                  busy
);

  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [2:0]         SEL_LAST   = 3'(NUM_PAT - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SW_RST,
    ST_BLANK
  } state_t;

  state_t             r_state;
  logic [2:0]         r_sel;
  logic [9:0]         r_led;
  logic [BLANK_W-1:0] r_blank;

  logic               r_btn_meta;
  logic               r_btn_sync;
  logic               r_btn_stable;
  logic               r_btn_pulse;
  logic [DEB_W-1:0]   r_deb_cnt;

  logic [DWELL_W-1:0] r_dwell;

  logic               w_btn_lvl;
  logic               w_dwell_run;
  logic               w_dwell_tick;
  logic               w_adv;
  logic [9:0]         w_pat_cur;

  // Two-flop synchronizer; resets to the released (high) level so a reset
  // never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_meta <= 1'b1;
      r_btn_sync <= 1'b1;
    end else begin
      r_btn_meta <= btn_n;
      r_btn_sync <= r_btn_meta;
    end
  end

  // 1 = pressed
  assign w_btn_lvl = ~r_btn_sync;

  // Debounce: the stable level only moves after DEB_CYCLES consecutive
  // cycles of disagreement; any agreeing cycle restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb_cnt    <= '0;
      r_btn_stable <= 1'b0;
      r_btn_pulse  <= 1'b0;
    end else begin
      r_btn_pulse <= 1'b0;
      if (w_btn_lvl == r_btn_stable) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_deb_cnt    <= '0;
        r_btn_stable <= w_btn_lvl;
        // pulse only on the press edge, releases are silent
        r_btn_pulse  <= w_btn_lvl;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  // Tick is gated by the same condition that lets the counter run, so a
  // count parked at its last value during pause cannot fire.
  assign w_dwell_run  = (r_state == ST_RUN) & sw_auto & ~sw_pause;
  assign w_dwell_tick = w_dwell_run & (r_dwell == DWELL_LAST);
  // A coincident button pulse and tick collapse into one advance.
  assign w_adv        = (r_state == ST_RUN) & (r_btn_pulse | w_dwell_tick);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwell <= '0;
    end else if (!sw_auto || w_adv) begin
      r_dwell <= '0;
    end else if (w_dwell_run) begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  // Output mux; unused sel codes (never reached) give zero.
  always_comb begin
    w_pat_cur = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      if (r_sel == 3'(i)) begin
        w_pat_cur = pat_in[i*10 +: 10];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SW_RST;
      r_sel   <= '0;
      r_led   <= '0;
      r_blank <= '0;
    end else begin
      r_led <= (r_state == ST_RUN) ? w_pat_cur : '0;
      case (r_state)
        ST_RUN: begin
          if (w_adv) begin
            r_sel   <= (r_sel == SEL_LAST) ? 3'd0 : r_sel + 3'd1;
            r_state <= ST_SW_RST;
          end
        end
        ST_SW_RST: begin
          r_blank <= '0;
          r_state <= (BLANK_CYCLES == 0) ? ST_RUN : ST_BLANK;
        end
        ST_BLANK: begin
          if (r_blank == BLANK_LAST) begin
            r_state <= ST_RUN;
          end else begin
            r_blank <= r_blank + 1'b1;
          end
        end
        default: r_state <= ST_SW_RST;
      endcase
    end
  end

  // rst is folded in combinationally so generators see reset in the same
  // cycle the sequencer does.
  always_comb begin
    pat_rst = '0;
    pat_en  = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      pat_rst[i] = rst | ((r_state == ST_SW_RST) & (r_sel == 3'(i)));
      pat_en[i]  = ~rst & (r_state == ST_RUN) & (r_sel == 3'(i)) & ~sw_pause;
    end
  end

  assign led  = r_led;
  assign sel  = r_sel;
  assign busy = (r_state != ST_RUN);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer with NUM_PAT=4, DEB_CYCLES=4, DWELL_CYCLES=16, BLANK_CYCLES=3.
// Every pattern switch the stimulus expects is queued; a monitor checks each SW_RST cycle against the queue.
// Inputs change 1 time unit after the rising edge; direct checks sample there, the monitor on the falling edge.
module tb_led_pattern_sequencer;

  localparam logic [9:0] P0 = 10'h155;
  localparam logic [9:0] P1 = 10'h0A1;
  localparam logic [9:0] P2 = 10'h1B2;
  localparam logic [9:0] P3 = 10'h2C3;
  localparam logic [9:0] P0B = 10'h2AA;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_n;
  logic        sw_auto;
  logic        sw_pause;
  logic [39:0] pat_in;
  logic [3:0]  pat_rst;
  logic [3:0]  pat_en;
  logic [9:0]  led;
  logic [2:0]  sel;
  logic        busy;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [2:0]  exp_q[$];
  logic [2:0]  mon_exp;

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .NUM_PAT      (4),
    .DEB_CYCLES   (4),
    .DWELL_CYCLES (16),
    .BLANK_CYCLES (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .sw_auto  (sw_auto),
    .sw_pause (sw_pause),
    .pat_in   (pat_in),
    .pat_rst  (pat_rst),
    .pat_en   (pat_en),
    .led      (led),
    .sel      (sel),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int len);
    btn_n = 1'b0;
    cycles(len);
    btn_n = 1'b1;
  endtask

  // Drop rst and walk the power-on switch: 1 SW_RST cycle, 3 blank cycles,
  // then RUN with the first LED value one cycle later.
  task automatic release_seq(input logic [9:0] p0);
    exp_q.push_back(3'd0);
    rst = 1'b0;
    #1;
    chk("rel_pat_rst", pat_rst, 4'b0001);
    chk("rel_busy", busy, 1);
    for (int k = 0; k < 3; k++) begin
      cycles(1);
      chk("blank_busy", busy, 1);
      chk("blank_led", led, 0);
      chk("blank_pat_rst", pat_rst, 0);
    end
    cycles(1);
    chk("run_busy", busy, 0);
    chk("run_pat_en", pat_en, 4'b0001);
    chk("run_led_first", led, 0);
    cycles(1);
    chk("run_led", led, p0);
  endtask

  // Scoreboard monitor: every SW_RST cycle outside reset must match the
  // next queued expected selection.
  always @(negedge clk) begin
    if (!rst && pat_rst != 4'b0000) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_switch: got sel=%0d pat_rst=%b, expected no switch (t=%0t)",
                 sel, pat_rst, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("switch_sel", sel, mon_exp);
        chk("switch_pat_rst", pat_rst, 4'b0001 << mon_exp);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    btn_n    = 1'b1;
    sw_auto  = 1'b0;
    sw_pause = 1'b0;
    pat_in   = {P3, P2, P1, P0};
    cycles(3);
    chk("rst_pat_rst", pat_rst, 4'b1111);
    chk("rst_pat_en", pat_en, 0);
    chk("rst_led", led, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 1);

    // 1. reset release
    release_seq(P0);
    pat_in[9:0] = P0B;
    cycles(1);
    chk("led_follow", led, P0B);

    // 2. bounces shorter than the debounce time are ignored
    for (int l = 1; l <= 3; l++) begin
      press(l);
      cycles(8);
      chk("bounce_sel", sel, 0);
    end
    // real press: advance lands 7 cycles after btn_n falls
    exp_q.push_back(3'd1);
    btn_n = 1'b0;
    cycles(6);
    chk("press_sel_pre", sel, 0);
    cycles(1);
    chk("press_sel", sel, 1);
    chk("press_busy", busy, 1);
    cycles(3);
    btn_n = 1'b1;
    cycles(15);
    chk("release_sel", sel, 1);
    chk("release_led", led, P1);

    exp_q.push_back(3'd2);
    press(10);
    cycles(15);
    exp_q.push_back(3'd3);
    press(10);
    cycles(15);
    chk("manual_sel3", sel, 3);

    // 3. auto mode wraps 3 -> 0 after 16 RUN cycles, then 16 RUN cycles again
    sw_auto = 1'b1;
    exp_q.push_back(3'd0);
    cycles(15);
    chk("auto_pre", sel, 3);
    cycles(1);
    chk("auto_wrap", sel, 0);
    exp_q.push_back(3'd1);
    cycles(19);
    chk("auto_pre2", sel, 0);
    cycles(1);
    chk("auto_next", sel, 1);

    // 4. pause after 8 dwell counts
    cycles(12);
    sw_pause = 1'b1;
    #1;
    chk("pause_en", pat_en, 0);
    cycles(100);
    chk("pause_sel", sel, 1);
    chk("pause_led", led, P1);
    chk("pause_busy", busy, 0);
    chk("pause_en_hold", pat_en, 0);
    sw_pause = 1'b0;
    exp_q.push_back(3'd2);
    cycles(7);
    chk("unpause_pre", sel, 1);
    cycles(1);
    chk("unpause_adv", sel, 2);

    // 5. button pulse coinciding with the dwell tick gives one advance
    exp_q.push_back(3'd3);
    cycles(13);
    btn_n = 1'b0;
    cycles(6);
    chk("sim_pre", sel, 2);
    cycles(1);
    chk("sim_adv", sel, 3);
    cycles(3);
    btn_n = 1'b1;
    // next tick wraps to 0; a press whose pulse lands in BLANK is dropped
    exp_q.push_back(3'd0);
    cycles(13);
    btn_n = 1'b0;
    cycles(4);
    chk("drop_wrap", sel, 0);
    chk("drop_busy_sw", busy, 1);
    sw_auto = 1'b0;
    cycles(6);
    btn_n = 1'b1;
    chk("drop_run", busy, 0);
    chk("drop_sel", sel, 0);
    cycles(20);
    chk("drop_sel_late", sel, 0);

    // 6. reset mid-BLANK with sel=2
    exp_q.push_back(3'd1);
    press(10);
    cycles(15);
    exp_q.push_back(3'd2);
    btn_n = 1'b0;
    cycles(7);
    chk("pre_rst_sel", sel, 2);
    cycles(2);
    chk("pre_rst_blank", busy, 1);
    rst = 1'b1;
    cycles(1);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_led", led, 0);
    chk("mid_rst_pat_rst", pat_rst, 4'b1111);
    chk("mid_rst_pat_en", pat_en, 0);
    btn_n = 1'b1;
    cycles(2);
    release_seq(P0B);

    cycles(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
